// File: rtl/iq_power_mean.sv
// ============================================================================
// Module   : iq_power_mean
// Purpose  : Block-averaged IQ power mean(I^2+Q^2) feeding the RMS sqrt stage.
//            Define IQPWR_ROUND_EN for a round-half-up divide (default truncates).
// Revision : 1.0
// ============================================================================
`default_nettype none

module iq_power_mean #(
    parameter int W        = 12,
    parameter int LOG2_LEN = 4,
    parameter int N        = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] in_i,
    input  logic [W-1:0] in_q,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int AW = 2*W + LOG2_LEN;
`ifdef IQPWR_ROUND_EN
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] C_HALF = SW'(1) << (LOG2_LEN - 1);
`else
    localparam int SW = AW;
    localparam logic [SW-1:0] C_HALF = '0;
`endif

    if ((N % 2) != 0 || N < 2*W) begin : g_bad_n
        $error("iq_power_mean: N must be even and >= 2*W");
    end
    if (LOG2_LEN < 1) begin : g_bad_len
        $error("iq_power_mean: LOG2_LEN must be >= 1");
    end

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                state;
    logic                  stall;
    logic                  accept;
    logic signed [2*W-1:0] i_prod;
    logic signed [2*W-1:0] q_prod;
    logic        [2*W-1:0] p;
    logic        [SW-1:0]  sum;
    logic        [SW-1:0]  mean;
    logic                  unused_bits;

    logic [2*W-2:0]    i2_q, i2_d;
    logic [2*W-2:0]    q2_q, q2_d;
    logic              s1_vld_q, s1_vld_d;
    logic              s1_last_q, s1_last_d;
    logic [LOG2_LEN-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [N-1:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    always_comb begin
        state = ST_ACCUM;
        if (out_valid_q && !out_ready) begin
            state = ST_HOLD;
        end
    end

    assign stall     = (state == ST_HOLD);
    // Combinational ready, forced low while reset is held
    assign in_ready  = !rst && !stall;
    assign accept    = in_valid && in_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    assign i_prod = $signed(in_i) * $signed(in_i);
    assign q_prod = $signed(in_q) * $signed(in_q);
    assign p      = {1'b0, i2_q} + {1'b0, q2_q};
    assign sum    = SW'(acc_q) + SW'(p) + C_HALF;
    assign mean   = sum >> LOG2_LEN;

    // Squares never use the sign bit; mean upper bits are always zero
    assign unused_bits = ^{i_prod[2*W-1], q_prod[2*W-1], mean[SW-1:2*W]};

    always_comb begin
        i2_d        = i2_q;
        q2_d        = q2_q;
        s1_vld_d    = s1_vld_q;
        s1_last_d   = s1_last_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            s1_vld_d  = 1'b0;
            s1_last_d = 1'b0;
            cnt_d     = '0;
            acc_d     = '0;
        end else if (!stall) begin
            s1_vld_d  = accept;
            s1_last_d = 1'b0;
            if (accept) begin
                i2_d      = i_prod[2*W-2:0];
                q2_d      = q_prod[2*W-2:0];
                s1_last_d = (cnt_q == {LOG2_LEN{1'b1}});
                cnt_d     = cnt_q + 1'b1;
            end
            if (s1_vld_q) begin
                if (s1_last_q) begin
                    out_data_d          = '0;
                    out_data_d[2*W-1:0] = mean[2*W-1:0];
                    out_valid_d         = 1'b1;
                    acc_d               = '0;
                end else begin
                    acc_d = acc_q + AW'(p);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i2_q        <= '0;
            q2_q        <= '0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            i2_q        <= i2_d;
            q2_q        <= q2_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iq_power_mean.sv
// ============================================================================
// Module   : tb_iq_power_mean
// Purpose  : Directed vector bench for iq_power_mean (W=12, LOG2_LEN=4, N=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iq_power_mean;

    localparam int W = 12;
    localparam int L = 4;
    localparam int N = 32;
`ifdef IQPWR_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        string               name;
        logic signed [W-1:0] i;
        logic signed [W-1:0] q;
        logic signed [W-1:0] li;
        logic signed [W-1:0] lq;
        logic [N-1:0]        exp_t;
        logic [N-1:0]        exp_r;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [W-1:0] in_i;
    logic [W-1:0] in_q;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           accepts = 0;
    logic [N-1:0] hs_data[$];
    vec_t         tab[8];

    iq_power_mean #(.W(W), .LOG2_LEN(L), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_i      (in_i),
        .in_q      (in_q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready && !clr) accepts <= accepts + 1;
        if (out_valid && out_ready) hs_data.push_back(out_data);
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // 16 back-to-back samples with out_ready=1, then check 2-cycle latency and 1-cycle pulse
    task automatic run_block(input vec_t v);
        logic [N-1:0] e;
        e = RND ? v.exp_r : v.exp_t;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_i     = (k == 15) ? v.li : v.i;
            in_q     = (k == 15) ? v.lq : v.q;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({v.name, ".vld_k"}, N'(out_valid), N'(0));
        @(posedge clk); #1;
        check({v.name, ".vld_k1"}, N'(out_valid), N'(1));
        check({v.name, ".data"}, out_data, e);
        @(posedge clk); #1;
        check({v.name, ".vld_k2"}, N'(out_valid), N'(0));
    endtask

    initial begin
        int base_a;
        int base_h;

        tab[0] = '{"tone",     12'sd3,     12'sd4,     12'sd3,     12'sd4,     32'd25,         32'd25};
        tab[1] = '{"fs_neg",   -12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, 32'h0080_0000,  32'h0080_0000};
        tab[2] = '{"fs_pos",   12'sd2047,  12'sd0,     12'sd2047,  12'sd0,     32'd4190209,    32'd4190209};
        tab[3] = '{"round",    12'sd0,     12'sd0,     12'sd3,     12'sd0,     32'd0,          32'd1};
        tab[4] = '{"ones",     12'sd1,     12'sd1,     12'sd1,     12'sd1,     32'd2,          32'd2};
        tab[5] = '{"mixsign",  -12'sd1,    12'sd5,     -12'sd1,    12'sd5,     32'd26,         32'd26};
        tab[6] = '{"big",      12'sd100,   -12'sd100,  12'sd100,   -12'sd100,  32'd20000,      32'd20000};
        tab[7] = '{"halfup",   12'sd1,     12'sd1,     12'sd3,     12'sd2,     32'd2,          32'd3};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_i = '0; in_q = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", N'(in_ready), N'(0));
        check("rst.out_valid", N'(out_valid), N'(0));
        check("rst.out_data", out_data, N'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst.in_ready", N'(in_ready), N'(1));

        for (int t = 0; t < 8; t++) run_block(tab[t]);

        // Backpressure: 32 samples of (1,1), out_ready low for the first 40 cycles
        base_a = accepts;
        base_h = hs_data.size();
        in_i = 12'd1; in_q = 12'd1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            in_valid  = (accepts - base_a) < 32;
            out_ready = (cyc >= 40);
            @(posedge clk); #1;
            if (cyc == 30) begin
                check("bp.hold_vld", N'(out_valid), N'(1));
                check("bp.hold_data", out_data, N'(2));
                check("bp.in_ready", N'(in_ready), N'(0));
                check("bp.accepts_stalled", N'(accepts - base_a), N'(17));
            end
        end
        in_valid = 1'b0;
        check("bp.results", N'(hs_data.size() - base_h), N'(2));
        if (hs_data.size() - base_h >= 2) begin
            check("bp.first", hs_data[base_h], N'(2));
            check("bp.second", hs_data[base_h+1], N'(2));
        end
        check("bp.accepts_total", N'(accepts - base_a), N'(32));
        check("bp.idle_vld", N'(out_valid), N'(0));

        // clr mid-block: 7 x (100,0) then clr with a sample that must be dropped
        out_ready = 1'b1;
        base_h = hs_data.size();
        in_i = 12'd100; in_q = 12'd0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        clr = 1'b1;
        #1;
        check("clr.in_ready", N'(in_ready), N'(1));
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr.no_vld", N'(out_valid), N'(0));
        run_block('{"after_clr", 12'sd1, 12'sd0, 12'sd1, 12'sd0, 32'd1, 32'd1});
        check("clr.single", N'(hs_data.size() - base_h), N'(1));

        // Async reset with a pending result and a partial block in flight
        out_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            in_i     = (k == 16) ? 12'd100 : 12'd3;
            in_q     = (k == 16) ? 12'd0   : 12'd4;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("arst.pending_vld", N'(out_valid), N'(1));
        check("arst.pending_data", out_data, N'(25));
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", N'(out_valid), N'(0));
        check("arst.out_data", out_data, N'(0));
        check("arst.in_ready", N'(in_ready), N'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        run_block('{"after_rst", 12'sd3, 12'sd4, 12'sd3, 12'sd4, 32'd25, 32'd25});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
